// File: rtl/memory_stage.sv
// Memory stage of the pipeline: word-addressed data memory, load/store execution,
// misaligned-access fault detection and a registered hand-off to write-back.
`ifndef DWIDTH
`define DWIDTH 32
`endif

module memory_stage #(
  parameter int DEPTH = 64,
  parameter int ABITS = 6
) (
  input  logic               ms_i_clk,
  input  logic               ms_i_rst,
  input  logic               ms_i_ce,
  input  logic [`DWIDTH-1:0] ms_i_alu_value,
  input  logic [`DWIDTH-1:0] ms_i_data_rt,
  input  logic               ms_i_mem_read,
  input  logic               ms_i_mem_write,
  input  logic               ms_i_reg_write,
  input  logic               ms_i_mem_to_reg,
  input  logic [4:0]         ms_i_rd_addr,
  input  logic               ms_i_stall,
  input  logic               ms_i_flush,
  output logic               ms_o_ce,
  output logic               ms_o_reg_write,
  output logic [4:0]         ms_o_rd_addr,
  output logic [`DWIDTH-1:0] ms_o_wb_data,
  output logic               ms_o_misaligned,
  output logic [7:0]         ms_o_fault_cnt
);

  localparam int DW = `DWIDTH;

  // Handshake: ms_i_ce is the upstream valid and ms_i_stall is the inverse of the
  // downstream ready. A transfer happens when ce=1, stall=0 and flush=0; flush
  // overrides both and turns the next output into a bubble.

  logic [DW-1:0]    mem_q [DEPTH];

  logic             ce_q,        ce_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       rd_addr_q,   rd_addr_d;
  logic [DW-1:0]    wb_data_q,   wb_data_d;
  logic             misaligned_q, misaligned_d;
  logic [7:0]       fault_cnt_q, fault_cnt_d;

  logic [ABITS-1:0] word_idx;
  logic [DW-1:0]    rd_word;
  logic             mem_access;
  logic             misaligned;
  logic             accept;
  logic             bubble;
  logic             mem_we;

  // Address bits above the memory size wrap; they are intentionally not decoded.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^ms_i_alu_value[DW-1:ABITS+2];

  assign word_idx   = ms_i_alu_value[ABITS+1:2];
  assign rd_word    = mem_q[word_idx];
  assign mem_access = ms_i_mem_read | ms_i_mem_write;
  assign misaligned = mem_access & (ms_i_alu_value[1:0] != 2'b00);
  assign accept     = ms_i_ce & ~ms_i_stall & ~ms_i_flush;
  assign bubble     = ms_i_flush | (~ms_i_ce & ~ms_i_stall);

  always_comb begin
    ce_d         = ce_q;
    reg_write_d  = reg_write_q;
    rd_addr_d    = rd_addr_q;
    wb_data_d    = wb_data_q;
    misaligned_d = 1'b0;
    fault_cnt_d  = fault_cnt_q;
    mem_we       = 1'b0;

    if (bubble) begin
      ce_d        = 1'b0;
      reg_write_d = 1'b0;
      rd_addr_d   = 5'd0;
      wb_data_d   = '0;
    end else if (accept) begin
      ce_d      = 1'b1;
      rd_addr_d = ms_i_rd_addr;
      if (misaligned) begin
        reg_write_d  = 1'b0;
        wb_data_d    = '0;
        misaligned_d = 1'b1;
        if (fault_cnt_q != 8'hFF) begin
          fault_cnt_d = fault_cnt_q + 8'd1;
        end
      end else begin
        reg_write_d = ms_i_reg_write;
        // rd_word is the pre-write contents, so a same-cycle store is not forwarded.
        wb_data_d   = ms_i_mem_to_reg ? rd_word : ms_i_alu_value;
        mem_we      = ms_i_mem_write & ~ms_i_rst;
      end
    end
  end

  always_ff @(posedge ms_i_clk or posedge ms_i_rst) begin
    if (ms_i_rst) begin
      ce_q         <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_addr_q    <= 5'd0;
      wb_data_q    <= '0;
      misaligned_q <= 1'b0;
      fault_cnt_q  <= 8'd0;
    end else begin
      ce_q         <= ce_d;
      reg_write_q  <= reg_write_d;
      rd_addr_q    <= rd_addr_d;
      wb_data_q    <= wb_data_d;
      misaligned_q <= misaligned_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge ms_i_clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= ms_i_data_rt;
    end
  end

  assign ms_o_ce         = ce_q;
  assign ms_o_reg_write  = reg_write_q;
  assign ms_o_rd_addr    = rd_addr_q;
  assign ms_o_wb_data    = wb_data_q;
  assign ms_o_misaligned = misaligned_q;
  assign ms_o_fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, reset and saturation
// sequences, then randomized traffic against a behavioural memory-stage model.
`ifndef DWIDTH
`define DWIDTH 32
`endif

module tb_memory_stage;

  localparam int DEPTH = 64;
  localparam int ABITS = 6;
  localparam int W     = `DWIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         ce, stall, flush, mem_read, mem_write, reg_write, mem_to_reg;
  logic [W-1:0] alu_value, data_rt;
  logic [4:0]   rd_addr;

  logic         o_ce, o_reg_write, o_misaligned;
  logic [4:0]   o_rd_addr;
  logic [W-1:0] o_wb_data;
  logic [7:0]   o_fault_cnt;

  memory_stage #(.DEPTH(DEPTH), .ABITS(ABITS)) dut (
    .ms_i_clk        (clk),
    .ms_i_rst        (rst),
    .ms_i_ce         (ce),
    .ms_i_alu_value  (alu_value),
    .ms_i_data_rt    (data_rt),
    .ms_i_mem_read   (mem_read),
    .ms_i_mem_write  (mem_write),
    .ms_i_reg_write  (reg_write),
    .ms_i_mem_to_reg (mem_to_reg),
    .ms_i_rd_addr    (rd_addr),
    .ms_i_stall      (stall),
    .ms_i_flush      (flush),
    .ms_o_ce         (o_ce),
    .ms_o_reg_write  (o_reg_write),
    .ms_o_rd_addr    (o_rd_addr),
    .ms_o_wb_data    (o_wb_data),
    .ms_o_misaligned (o_misaligned),
    .ms_o_fault_cnt  (o_fault_cnt)
  );

  typedef struct {
    logic ce, stall, flush, rd, wr, rw, m2r;
    logic [W-1:0] alu, data;
    logic [4:0] rda;
  } in_t;

  typedef struct {
    in_t i;
    logic e_ce, e_rw;
    logic [4:0] e_rd;
    logic [W-1:0] e_wb;
    logic e_mis;
    logic [7:0] e_cnt;
  } vec_t;

  // ---------------- reference model state ----------------
  logic         m_ce, m_rw, m_mis;
  logic [4:0]   m_rd;
  logic [W-1:0] m_wb;
  int           m_cnt;
  logic [W-1:0] mem_m [DEPTH];
  logic [W-1:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic in_t mk(input logic c, s, f, r, w, rw, m2r,
                             input logic [W-1:0] alu, data, input logic [4:0] rda);
    in_t v;
    v.ce = c; v.stall = s; v.flush = f; v.rd = r; v.wr = w; v.rw = rw; v.m2r = m2r;
    v.alu = alu; v.data = data; v.rda = rda;
    return v;
  endfunction

  function automatic logic [W-1:0] init_word(input int i);
    return (W'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input in_t v);
    ce = v.ce; stall = v.stall; flush = v.flush;
    mem_read = v.rd; mem_write = v.wr; reg_write = v.rw; mem_to_reg = v.m2r;
    alu_value = v.alu; data_rt = v.data; rd_addr = v.rda;
  endtask

  task automatic model_reset();
    m_ce = 0; m_rw = 0; m_mis = 0; m_rd = 0; m_wb = 0; m_cnt = 0;
  endtask

  // Behavioural stage: one instruction either moves through, is held, or is dropped.
  task automatic model_step(input in_t v);
    int idx;
    bit bad;
    logic [W-1:0] old;
    if (v.flush || (!v.ce && !v.stall)) begin
      m_ce = 0; m_rw = 0; m_rd = 0; m_wb = 0; m_mis = 0;
    end else if (v.stall) begin
      m_mis = 0;
    end else begin
      idx = int'(v.alu % (DEPTH * 4)) / 4;
      bad = (v.rd || v.wr) && (v.alu % 4 != 0);
      old = mem_m[idx];
      m_ce = 1; m_rd = v.rda; m_mis = bad;
      if (bad) begin
        m_rw = 0; m_wb = 0;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else begin
        m_rw = v.rw;
        m_wb = v.m2r ? old : v.alu;
        if (v.wr) mem_m[idx] = v.data;
      end
    end
    exp_q.push_back(m_wb);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs(input string tag);
    logic [W-1:0] exp_wb;
    exp_wb = exp_q.pop_front();
    chk({tag, ".ce"},  W'(o_ce),         W'(m_ce));
    chk({tag, ".rw"},  W'(o_reg_write),  W'(m_rw));
    chk({tag, ".rd"},  W'(o_rd_addr),    W'(m_rd));
    chk({tag, ".wb"},  o_wb_data,        exp_wb);
    chk({tag, ".mis"}, W'(o_misaligned), W'(m_mis));
    chk({tag, ".cnt"}, W'(o_fault_cnt),  W'(m_cnt));
  endtask

  task automatic cycle(input in_t v, input string tag);
    @(negedge clk);
    drive(v);
    model_step(v);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{mk(1,0,0,0,1,0,0, 32'h10,  32'hDEADBEEF, 5'd0), 1,0,5'd0, 32'h10,       0,8'd0};
    tbl[1]  = '{mk(1,0,0,1,0,1,1, 32'h10,  32'h0,        5'd5), 1,1,5'd5, 32'hDEADBEEF, 0,8'd0};
    tbl[2]  = '{mk(1,0,0,0,1,0,0, 32'h04,  32'h12345678, 5'd0), 1,0,5'd0, 32'h04,       0,8'd0};
    tbl[3]  = '{mk(1,0,0,1,0,1,1, 32'h104, 32'h0,        5'd6), 1,1,5'd6, 32'h12345678, 0,8'd0};
    tbl[4]  = '{mk(1,0,0,0,1,0,0, 32'h08,  32'h1,        5'd0), 1,0,5'd0, 32'h08,       0,8'd0};
    tbl[5]  = '{mk(1,0,0,1,1,1,1, 32'h08,  32'h2,        5'd7), 1,1,5'd7, 32'h1,        0,8'd0};
    tbl[6]  = '{mk(1,0,0,1,0,1,1, 32'h08,  32'h0,        5'd7), 1,1,5'd7, 32'h2,        0,8'd0};
    tbl[7]  = '{mk(1,0,0,0,0,1,0, 32'h07,  32'h0,        5'd3), 1,1,5'd3, 32'h07,       0,8'd0};
    tbl[8]  = '{mk(1,1,0,1,0,0,1, 32'h13,  32'h0,        5'd9), 1,1,5'd3, 32'h07,       0,8'd0};
    tbl[9]  = '{mk(1,1,0,0,1,0,0, 32'h20,  32'h55,       5'd1), 1,1,5'd3, 32'h07,       0,8'd0};
    tbl[10] = '{mk(0,1,0,0,0,1,0, 32'h44,  32'h0,        5'd2), 1,1,5'd3, 32'h07,       0,8'd0};
    tbl[11] = '{mk(1,1,1,0,0,1,0, 32'h44,  32'h0,        5'd2), 0,0,5'd0, 32'h0,        0,8'd0};
    tbl[12] = '{mk(1,0,0,1,0,1,1, 32'h13,  32'h0,        5'd9), 1,0,5'd9, 32'h0,        1,8'd1};
    tbl[13] = '{mk(1,1,0,1,0,1,1, 32'h13,  32'h0,        5'd4), 1,0,5'd9, 32'h0,        0,8'd1};
    tbl[14] = '{mk(0,0,0,1,0,1,1, 32'h10,  32'h0,        5'd4), 0,0,5'd0, 32'h0,        0,8'd1};
    tbl[15] = '{mk(1,0,0,0,1,1,0, 32'h11,  32'hFFFFFFFF, 5'd2), 1,0,5'd2, 32'h0,        1,8'd2};
    tbl[16] = '{mk(1,0,0,1,0,1,1, 32'h10,  32'h0,        5'd4), 1,1,5'd4, 32'hDEADBEEF, 0,8'd2};

    drive(mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 5'd0));
    model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

    // Reset state.
    #12;
    chk("rst.ce",  W'(o_ce),         '0);
    chk("rst.rw",  W'(o_reg_write),  '0);
    chk("rst.rd",  W'(o_rd_addr),    '0);
    chk("rst.wb",  o_wb_data,        '0);
    chk("rst.mis", W'(o_misaligned), '0);
    chk("rst.cnt", W'(o_fault_cnt),  '0);
    @(negedge clk);
    rst = 1'b0;

    // Give every word a known value so later loads are predictable.
    for (int i = 0; i < DEPTH; i++)
      cycle(mk(1,0,0,0,1,0,0, W'(i * 4), init_word(i), 5'd0), "init");

    // Directed vector table.
    for (int k = 0; k < 17; k++) begin
      string t;
      t = $sformatf("vec%0d", k);
      cycle(tbl[k].i, t);
      chk({t, ".t_ce"},  W'(o_ce),         W'(tbl[k].e_ce));
      chk({t, ".t_rw"},  W'(o_reg_write),  W'(tbl[k].e_rw));
      chk({t, ".t_rd"},  W'(o_rd_addr),    W'(tbl[k].e_rd));
      chk({t, ".t_wb"},  o_wb_data,        tbl[k].e_wb);
      chk({t, ".t_mis"}, W'(o_misaligned), W'(tbl[k].e_mis));
      chk({t, ".t_cnt"}, W'(o_fault_cnt),  W'(tbl[k].e_cnt));
    end

    // 300 further misaligned accesses drive the counter into saturation.
    for (int k = 0; k < 300; k++)
      cycle(mk(1,0,0,1,0,1,1, W'($urandom_range(0, 255) * 4 + $urandom_range(1, 3)),
               32'h0, 5'd1), "sat");
    chk("sat.final", W'(o_fault_cnt), W'(255));

    // Asynchronous reset while a store to 0x20 is presented.
    @(negedge clk);
    drive(mk(1,0,0,0,1,0,0, 32'h20, 32'hAA, 5'd1));
    #2 rst = 1'b1;
    #1;
    chk("arst.ce",  W'(o_ce),         '0);
    chk("arst.rw",  W'(o_reg_write),  '0);
    chk("arst.rd",  W'(o_rd_addr),    '0);
    chk("arst.mis", W'(o_misaligned), '0);
    chk("arst.cnt", W'(o_fault_cnt),  '0);
    model_reset();
    @(posedge clk);
    #1;
    chk("arst.hold_wb", o_wb_data, '0);
    rst = 1'b0;
    cycle(mk(1,0,0,1,0,1,1, 32'h20, 32'h0, 5'd3), "post_rst");
    chk("post_rst.keep", o_wb_data, init_word(8));

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      in_t v;
      v.ce    = ($urandom_range(0, 9) < 8);
      v.stall = ($urandom_range(0, 9) < 2);
      v.flush = ($urandom_range(0, 19) == 0);
      v.rd    = $urandom_range(0, 1);
      v.wr    = $urandom_range(0, 1);
      v.rw    = $urandom_range(0, 1);
      v.m2r   = $urandom_range(0, 1);
      v.alu   = $urandom() & ~32'h3;
      if ($urandom_range(0, 3) == 0) v.alu[1:0] = 2'($urandom_range(1, 3));
      v.data  = $urandom();
      v.rda   = 5'($urandom_range(0, 31));
      cycle(v, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of DWIDTH-bit data-memory words (power of two).
REQ-002 SHALL have parameter ABITS, default 6, meaning log2(DEPTH), the word-index width.
REQ-003 SHALL have port ms_i_clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port ms_i_rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port ms_i_ce  input  1  valid from the execute stage (its es_o_ce).
REQ-006 SHALL have port ms_i_alu_value  input  `DWIDTH  ALU result; byte address for loads and stores.
REQ-007 SHALL have port ms_i_data_rt  input  `DWIDTH  store data.
REQ-008 SHALL have ports ms_i_mem_read and ms_i_mem_write  input  1 each  load and store requests.
REQ-009 SHALL have ports ms_i_reg_write and ms_i_mem_to_reg  input  1 each  write-back controls.
REQ-010 SHALL have port ms_i_rd_addr  input  5  destination register.
REQ-011 SHALL have port ms_i_stall  input  1  hold the stage.
REQ-012 SHALL have port ms_i_flush  input  1  insert a bubble.
REQ-013 SHALL have output ms_o_ce  1  valid to write-back.
REQ-014 SHALL have output ms_o_reg_write  1  the gated register-write enable.
REQ-015 SHALL have output ms_o_rd_addr  5  the registered destination.
REQ-016 SHALL have output ms_o_wb_data  `DWIDTH  the write-back value.
REQ-017 SHALL have output ms_o_misaligned  1  one-cycle fault pulse.
REQ-018 SHALL have output ms_o_fault_cnt  8  saturating count of misaligned accesses.

Function
REQ-019 All outputs SHALL be registered, with 1-cycle latency from inputs sampled at a rising edge.
REQ-020 Word index SHALL be ms_i_alu_value[ABITS+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-021 An access SHALL be misaligned when (mem_read | mem_write) and alu_value[1:0] != 0.
REQ-022 An accepted cycle SHALL be ce=1, stall=0, flush=0.
REQ-023 On an accepted cycle, ms_o_ce SHALL be 1, ms_o_rd_addr SHALL be rd_addr, and ms_o_wb_data SHALL be mem[index] if mem_to_reg, else alu_value.
REQ-024 On an accepted store that is not misaligned, mem[index] SHALL be written with data_rt at the edge.
REQ-025 A load in the same cycle as a store to the same index SHALL return the pre-write contents.
REQ-026 On an accepted misaligned access: no memory write; ms_o_reg_write=0; ms_o_wb_data=0; ms_o_misaligned=1 for exactly one cycle; ms_o_fault_cnt +1, saturating at 255.
REQ-027 On an accepted access that is not misaligned, ms_o_reg_write SHALL equal ms_i_reg_write and ms_o_misaligned SHALL be 0.
REQ-028 stall=1 with flush=0 SHALL hold all outputs, memory and counter unchanged; ms_o_misaligned SHALL drop to 0 after one cycle even while stalled.
REQ-029 flush=1 SHALL win over stall and ce: next outputs bubble (ce, reg_write, misaligned = 0; rd_addr, wb_data = 0); no memory write; counter unchanged.
REQ-030 ce=0 with stall=0 SHALL produce a bubble as in REQ-029.
REQ-031 Simultaneous mem_read and mem_write SHALL perform the write and return pre-write data when mem_to_reg=1.

Reset
REQ-032 ms_i_rst=1 SHALL immediately force all outputs, including ms_o_fault_cnt, to 0, independent of the clock.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 A store presented in a cycle where reset is asserted SHALL NOT be performed.
REQ-035 The first accepted edge after reset deassertion SHALL behave per REQ-023.

Verification
REQ-036 Store 0xDEADBEEF at 0x10, then load 0x10 with mem_to_reg=1 -> wb_data=0xDEADBEEF and reg_write=1 one cycle after the load.
REQ-037 Store 0x12345678 at 0x04, then load 0x104 -> wb_data=0x12345678, showing wrap-around.
REQ-038 Load at 0x13 with reg_write=1 -> misaligned=1 for one cycle, reg_write=0, fault_cnt=1; then 300 misaligned accesses -> fault_cnt=255.
REQ-039 Hold stall=1 for 3 cycles after a valid ALU op (alu_value=7, rd=3) -> outputs stay ce=1, wb_data=7, rd_addr=3; asserting stall and flush together -> ce=0 next cycle.
REQ-040 Assert rst mid-stream while a store to 0x20 of 0xAA is presented -> outputs 0 asynchronously; a later load of 0x20 returns the prior contents, not 0xAA.
REQ-041 Same-cycle read+write at 0x08 (old 0x1, new 0x2) -> wb_data=0x1; a following load -> 0x2.
